// File: rtl/uart_pkg.sv
// Types, default link parameters and helpers shared by the UART receive and transmit blocks.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int OVERSAMPLING_DEF = 8;
  localparam int DATA_BITS_DEF    = 8;

  function automatic logic MAJ3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones (idle serial line).
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: majority-voted mid-bit sampling, one-cycle done/error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING = OVERSAMPLING_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 sysclk_in,
  input  logic                 nrst_in,
  input  logic                 baudclk_in,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_done_out,
  output logic                 rx_err_out,
  output logic                 rx_busy_out
);

  localparam int M  = OVERSAMPLING / 2;
  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS);

  logic                 rxs;
  rx_state_t            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [1:0]           smp_q;
  logic [DATA_BITS-1:0] sh_q, data_q;
  logic                 done_q, err_q, armed_q;
  logic                 decide, last, maj;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk_i  (sysclk_in),
    .rst_ni (nrst_in),
    .d_i    (rx_serial_in),
    .q_o    (rxs)
  );

  assign decide = baudclk_in && (cnt_q == CW'(M + 1));
  assign last   = baudclk_in && (cnt_q == CW'(OVERSAMPLING - 1));
  // Third vote is the live sample taken on the decision tick itself.
  assign maj    = MAJ3(smp_q[0], smp_q[1], rxs);

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (baudclk_in && state_q != IDLE) begin
        cnt_q <= last ? '0 : cnt_q + CW'(1);
        if (cnt_q == CW'(M - 1)) smp_q[0] <= rxs;
        if (cnt_q == CW'(M))     smp_q[1] <= rxs;
      end
      unique case (state_q)
        IDLE: begin
          // After a framing error the line must go high once before a new start is accepted.
          if (!armed_q) armed_q <= rxs;
          else if (!rxs) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (decide && maj) state_q <= IDLE;
          else if (last) begin
            state_q <= DATA;
            bit_q   <= '0;
          end
        end
        DATA: begin
          if (decide) sh_q <= {maj, sh_q[DATA_BITS-1:1]};
          if (last) begin
            if (bit_q == BW'(DATA_BITS - 1)) state_q <= STOP;
            else                             bit_q   <= bit_q + BW'(1);
          end
        end
        STOP: begin
          // Leave at mid-stop so an immediately following start edge is caught.
          if (decide) begin
            state_q <= IDLE;
            if (maj) begin
              data_q <= sh_q;
              done_q <= 1'b1;
            end else begin
              err_q   <= 1'b1;
              armed_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data_out = data_q;
  assign rx_done_out = done_q;
  assign rx_err_out  = err_q;
  assign rx_busy_out = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-accurate serial driver, table of frames plus corner-case sequences.
module tb_uart_rx;

  localparam int OS   = 8;
  localparam int DIV  = 4;          // sysclk cycles per oversample tick (scaled-down baud)
  localparam int BITC = OS * DIV;   // sysclk cycles per bit

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       baud = 1'b0;
  logic       line = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_err, rx_busy;

  int tests = 0;
  int failed = 0;
  int err_cnt = 0;
  logic [7:0] got_q[$];

  uart_rx #(.OVERSAMPLING(OS), .DATA_BITS(8)) dut (
    .sysclk_in    (clk),
    .nrst_in      (nrst),
    .baudclk_in   (baud),
    .rx_serial_in (line),
    .rx_data_out  (rx_data),
    .rx_done_out  (rx_done),
    .rx_err_out   (rx_err),
    .rx_busy_out  (rx_busy)
  );

  always #5 clk = ~clk;

  int div_cnt = 0;
  always @(posedge clk) begin
    div_cnt <= (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
    baud    <= (div_cnt == DIV - 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (rx_done) begin
        got_q.push_back(rx_data);
        chk("busy_low_at_done", rx_busy, 0);
      end
      if (rx_err) err_cnt++;
      if (rx_done && rx_err) chk("done_and_err", 1, 0);
    end
  end

  task automatic send_bit(input logic v, input bit glitch);
    line = v;
    if (glitch) begin
      repeat (BITC / 2) @(negedge clk);
      line = ~v;
      repeat (DIV) @(negedge clk);
      line = v;
      repeat (BITC / 2 - DIV) @(negedge clk);
    end else
      repeat (BITC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_idx);
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(d[i], i == glitch_idx);
    send_bit(stop, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         idle_bits;
    int         glitch;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n0, e0;
    logic [7:0] rb;

    vecs[0] = '{8'hA5, 1'b1, 2, -1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0, -1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0, -1, 1, 0, 8'hFF};
    vecs[3] = '{8'h55, 1'b1, 0, -1, 1, 0, 8'h55};
    vecs[4] = '{8'h3C, 1'b0, 1, -1, 0, 1, 8'h55};
    vecs[5] = '{8'h81, 1'b1, 1, -1, 1, 0, 8'h81};
    vecs[6] = '{8'hF0, 1'b1, 1,  4, 1, 0, 8'hF0};
    vecs[7] = '{8'h6B, 1'b1, 0, -1, 1, 0, 8'h6B};

    repeat (5) @(negedge clk);
    chk("reset_data", rx_data, 0);
    chk("reset_done", rx_done, 0);
    chk("reset_err",  rx_err,  0);
    chk("reset_busy", rx_busy, 0);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      n0 = got_q.size();
      e0 = err_cnt;
      repeat (vecs[v].idle_bits) send_bit(1'b1, 0);
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].glitch);
      chk($sformatf("v%0d_done_cnt", v), got_q.size() - n0, vecs[v].exp_done);
      chk($sformatf("v%0d_err_cnt", v), err_cnt - e0, vecs[v].exp_err);
      chk($sformatf("v%0d_data", v), rx_data, vecs[v].exp_data);
      chk($sformatf("v%0d_busy", v), rx_busy, 0);
      if (vecs[v].exp_done == 1 && got_q.size() > n0)
        chk($sformatf("v%0d_pulse_data", v), got_q[$], vecs[v].exp_data);
    end

    // Short low glitch on the idle line: false start, no pulses.
    line = 1'b1;
    repeat (BITC) @(negedge clk);
    n0 = got_q.size(); e0 = err_cnt;
    line = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    line = 1'b1;
    repeat (3 * BITC) @(negedge clk);
    chk("glitch_no_done", got_q.size() - n0, 0);
    chk("glitch_no_err",  err_cnt - e0, 0);
    chk("glitch_idle",    rx_busy, 0);

    // Reset during bit 3 of 0x77, then a clean 0x12.
    n0 = got_q.size(); e0 = err_cnt;
    send_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    line = 1'b0;
    repeat (BITC / 2) @(negedge clk);
    chk("abort_busy_before_rst", rx_busy, 1);
    nrst = 1'b0;
    line = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_rst_busy", rx_busy, 0);
    chk("abort_rst_data", rx_data, 0);
    nrst = 1'b1;
    send_bit(1'b1, 0);
    chk("abort_no_done", got_q.size() - n0, 0);
    chk("abort_no_err",  err_cnt - e0, 0);
    send_frame(8'h12, 1'b1, -1);
    chk("after_abort_cnt",  got_q.size() - n0, 1);
    chk("after_abort_data", rx_data, 8'h12);

    // Back-to-back random bytes.
    e0 = err_cnt;
    for (int k = 0; k < 16; k++) begin
      rb = 8'($urandom_range(0, 255));
      n0 = got_q.size();
      send_frame(rb, 1'b1, -1);
      chk($sformatf("rand%0d_cnt", k), got_q.size() - n0, 1);
      chk($sformatf("rand%0d_data", k), rx_data, rb);
    end
    chk("rand_no_err", err_cnt - e0, 0);

    repeat (BITC) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
